display_scan: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It sits upstream of the anode/segment decoders and steps a digit index through 0..7 at a programmable rate. For each index it emits the digit select, a one-hot active-low anode vector and the 4-bit nibble to show. Display data is double-buffered, so a new 32-bit value only takes effect at a frame boundary and never tears mid-scan.

---
 rtl/display_scan.sv | 103 ++++++++++
 tb/tb_display_scan.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Eight-digit seven-segment scan controller: steps a digit index at a fixed
// dwell, double-buffers the display value and commits it only at frame wrap.
module display_scan #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  digit_en,
  output logic [3:0]  zi,
  output logic [7:0]  an,
  output logic [3:0]  nibble,
  output logic        frame_tick,
  output logic        upd_pend
);
  localparam int NUM_DIG = 8;
  localparam int CW      = $clog2(DIV);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [31:0]   pbuf_q, pbuf_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          wrap_q;
  logic          step, wrap;

  logic [3:0]         zi_q, zi_d;
  logic [7:0]         an_q, an_d;
  logic [3:0]         nib_q, nib_d;
  logic               ft_q;
  logic [NUM_DIG-1:0][3:0] digs;

  assign step = (cnt_q == CMAX);
  assign wrap = step && (idx_q == 3'd7);

  always_comb begin
    cnt_d    = step ? '0 : cnt_q + CW'(1);
    idx_d    = step ? idx_q + 3'd1 : idx_q;
    pend_d   = pend_q;
    pbuf_d   = pbuf_q;
    shadow_d = shadow_q;
    if (wrap && load) begin
      // Bypass: a load landing on the wrap goes straight to the display.
      shadow_d = data;
      pend_d   = 1'b0;
    end else if (wrap) begin
      if (pend_q) begin
        shadow_d = pbuf_q;
        pend_d   = 1'b0;
      end
    end else if (load) begin
      pbuf_d = data;
      pend_d = 1'b1;
    end
  end

  // digs[7] is the top nibble, which belongs to digit 0.
  assign digs = shadow_q;

  always_comb begin
    zi_d  = {1'b0, idx_q};
    nib_d = digs[3'd7 - idx_q];
  end

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_an
    assign an_d[k] = ~(digit_en[k] && (idx_q == 3'(NUM_DIG - 1 - k)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      pbuf_q   <= '0;
      shadow_q <= '0;
      wrap_q   <= 1'b0;
      zi_q     <= '0;
      an_q     <= 8'hFF;
      nib_q    <= '0;
      ft_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pbuf_q   <= pbuf_d;
      shadow_q <= shadow_d;
      wrap_q   <= wrap;
      zi_q     <= zi_d;
      an_q     <= an_d;
      nib_q    <= nib_d;
      // Delayed one extra stage so the pulse coincides with zi going 7->0.
      ft_q     <= wrap_q;
    end
  end

  assign zi         = zi_q;
  assign an         = an_q;
  assign nibble     = nib_q;
  assign frame_tick = ft_q;
  assign upd_pend   = pend_q;
endmodule

// File: tb/tb_display_scan.sv
// Directed plus random checks of display_scan at DIV=4 and DIV=2 against a
// cycle-count based reference model.
module tb_display_scan;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] data;
  logic [7:0]  digit_en;

  logic [3:0] zi4, nib4, zi2, nib2;
  logic [7:0] an4, an2;
  logic       ft4, up4, ft2, up2;

  int n_chk = 0;
  int n_fail = 0;

  // model state, index 0 = DIV 4, index 1 = DIV 2
  int          mn[2];
  logic [31:0] msh[2], mpb[2];
  logic        mpend[2], mwp[2];
  logic [3:0]  ezi[2], enib[2];
  logic [7:0]  ean[2];
  logic        eft[2], eup[2];

  always #5 clk = ~clk;

  display_scan #(.DIV(4)) u4 (
    .clk(clk), .rst(rst), .data(data), .load(load), .digit_en(digit_en),
    .zi(zi4), .an(an4), .nibble(nib4), .frame_tick(ft4), .upd_pend(up4));

  display_scan #(.DIV(2)) u2 (
    .clk(clk), .rst(rst), .data(data), .load(load), .digit_en(digit_en),
    .zi(zi2), .an(an2), .nibble(nib2), .frame_tick(ft2), .upd_pend(up2));

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge count since reset fully determines the scan position.
  task automatic model(input int i);
    int d, s, id;
    logic w;
    if (rst) begin
      mn[i] = 0; msh[i] = '0; mpb[i] = '0; mpend[i] = 1'b0; mwp[i] = 1'b0;
      ezi[i] = '0; ean[i] = 8'hFF; enib[i] = '0; eft[i] = 1'b0; eup[i] = 1'b0;
    end else begin
      d = dv(i);
      mn[i]++;
      s = mn[i] - 1;
      id = (s / d) % 8;
      w = ((mn[i] % (8 * d)) == 0);
      ezi[i]  = 4'(id);
      ean[i]  = digit_en[7 - id] ? ~(8'h80 >> id) : 8'hFF;
      enib[i] = 4'((msh[i] >> (28 - 4 * id)) & 32'hF);
      eft[i]  = mwp[i];
      mwp[i]  = w;
      if (w && load) begin
        msh[i] = data; mpend[i] = 1'b0;
      end else if (w) begin
        if (mpend[i]) begin msh[i] = mpb[i]; mpend[i] = 1'b0; end
      end else if (load) begin
        mpb[i] = data; mpend[i] = 1'b1;
      end
      eup[i] = mpend[i];
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [31:0] dt, input logic [7:0] en);
    rst = r; load = l; data = dt; digit_en = en;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("zi4", 32'(zi4), 32'(ezi[0]));   chk("an4", 32'(an4), 32'(ean[0]));
    chk("nib4", 32'(nib4), 32'(enib[0])); chk("ft4", 32'(ft4), 32'(eft[0]));
    chk("upd4", 32'(up4), 32'(eup[0]));
    chk("zi2", 32'(zi2), 32'(ezi[1]));   chk("an2", 32'(an2), 32'(ean[1]));
    chk("nib2", 32'(nib2), 32'(enib[1])); chk("ft2", 32'(ft2), 32'(eft[1]));
    chk("upd2", 32'(up2), 32'(eup[1]));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] en);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, en);
  endtask

  initial begin
    logic [7:0]  en;
    logic [31:0] rd;
    logic        ok;
    rst = 1'b1; load = 1'b0; data = '0; digit_en = 8'hFF;
    @(negedge clk);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 8'hFF);
    chk("rst_an", 32'(an4), 32'hFF);
    idle(80, 8'hFF);

    // load at mid digit 3 of the DIV=4 scan
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (mn[0] % 32 == 13) ok = 1'b1; else cyc(1'b0, 1'b0, 32'h0, 8'hFF);
    end
    chk("wait_d3", 32'(ok), 32'h1);
    cyc(1'b0, 1'b1, 32'h1234_5678, 8'hFF);
    chk("upd_rise", 32'(up4), 32'h1);
    idle(40, 8'hFF);

    // last load wins
    cyc(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hFF);
    idle(3, 8'hFF);
    cyc(1'b0, 1'b1, 32'hBBBB_BBBB, 8'hFF);
    idle(70, 8'hFF);

    // bypass load exactly on the DIV=4 wrap
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if ((mn[0] + 1) % 32 == 0) ok = 1'b1; else cyc(1'b0, 1'b0, 32'h0, 8'hFF);
    end
    chk("wait_wrap", 32'(ok), 32'h1);
    cyc(1'b0, 1'b1, 32'hC0C1_C2C3, 8'hFF);
    chk("bypass_noupd", 32'(up4), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 8'hFF);
    chk("bypass_vis", 32'(nib4), 32'hC);
    idle(34, 8'hFF);

    // blanking
    idle(40, 8'b1010_0101);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (ezi[0] == 4'd0 && mn[0] % 4 == 1) ok = 1'b1; else cyc(1'b0, 1'b0, 32'h0, 8'hA5);
    end
    chk("wait_zi0", 32'(ok), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 8'h25);
    cyc(1'b0, 1'b0, 32'h0, 8'hA5);
    idle(8, 8'hFF);

    // reset mid-frame with data pending
    cyc(1'b0, 1'b1, 32'h9876_5432, 8'hFF);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (ezi[0] == 4'd5 && mpend[0]) ok = 1'b1; else cyc(1'b0, 1'b0, 32'h0, 8'hFF);
    end
    chk("wait_zi5", 32'(ok), 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 8'hFF);
    chk("rst_mid_upd", 32'(up4), 32'h0);
    idle(40, 8'hFF);

    // random traffic, biased toward loads on the DIV=4 wrap
    en = 8'hFF;
    for (int k = 0; k < 700; k++) begin
      rd = $urandom;
      if ($urandom_range(0, 15) == 0) en = 8'($urandom);
      if ((mn[0] + 1) % 32 == 0)
        cyc(1'b0, 1'($urandom_range(0, 1)), rd, en);
      else
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rd, en);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
